// File: rtl/burst_sweep_ctrl.sv
// burst_sweep_ctrl: interrupter and chirp sequencer for the DRSSTC reference
// generator. Gates the reference into on/off bursts and ramps the generator
// period parameter once per microsecond inside each burst, saturating at the
// parameter limits.
//
// Output handshake: param_load is a one-cycle strobe; in the cycle it is high,
// gen_param carries a new, valid value. There is no back-pressure; the
// generator must accept the value in that cycle.
module burst_sweep_ctrl #(
    parameter int CLK_MHZ    = 100,
    parameter int PARAM_MAX  = 255,
    parameter int ON_US_MAX  = 255,
    parameter int OFF_US_MAX = 65535,
    parameter int LEAD_CYC   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               kill,
    input  logic [$clog2(ON_US_MAX+1)-1:0]     on_us,
    input  logic [$clog2(OFF_US_MAX+1)-1:0]    off_us,
    input  logic [$clog2(PARAM_MAX+1)-1:0]     param_start,
    input  logic [$clog2(PARAM_MAX+1)-1:0]     param_step,
    input  logic                               sweep_dn,
    output logic [$clog2(PARAM_MAX+1)-1:0]     gen_param,
    output logic                               param_load,
    output logic                               gate,
    output logic                               burst_done,
    output logic                               busy,
    output logic [1:0]                         dbg_state
);

    localparam int W     = $clog2(PARAM_MAX + 1);
    localparam int ON_W  = $clog2(ON_US_MAX + 1);
    localparam int OFF_W = $clog2(OFF_US_MAX + 1);
    localparam int PS_W  = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    // Prescaler times one microsecond; the us counter then spans the longest
    // window, so together they cover OFF_US_MAX*CLK_MHZ cycles.
    localparam int US_W  = (OFF_W > ON_W) ? OFF_W : ON_W;
    localparam int LD_W  = $clog2(LEAD_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_BURST = 2'd2,
        S_OFF   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ON_W-1:0]   on_sh_q, on_sh_d;
    logic [OFF_W-1:0]  off_sh_q, off_sh_d;
    logic [W-1:0]      step_sh_q, step_sh_d;
    logic              dn_sh_q, dn_sh_d;
    logic [W-1:0]      gen_q, gen_d;
    logic              load_q, load_d;
    logic              gate_q, gate_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [US_W-1:0]   us_q, us_d;
    logic [LD_W-1:0]   lead_q, lead_d;

    logic              tick;
    logic              do_latch;
    logic [PS_W-1:0]   presc_next;
    logic [US_W-1:0]   us_inc;
    logic [W:0]        sum_w, dif_w;
    logic [W-1:0]      swept;

    // Next-state, counter and output computation for the burst sequencer.
    always_comb begin
        state_d   = state_q;
        on_sh_d   = on_sh_q;
        off_sh_d  = off_sh_q;
        step_sh_d = step_sh_q;
        dn_sh_d   = dn_sh_q;
        gen_d     = gen_q;
        load_d    = 1'b0;
        gate_d    = gate_q;
        done_d    = 1'b0;
        presc_d   = presc_q;
        us_d      = us_q;
        lead_d    = lead_q;
        do_latch  = 1'b0;

        tick       = (presc_q == PS_W'(CLK_MHZ - 1));
        presc_next = tick ? '0 : presc_q + PS_W'(1);
        us_inc     = us_q + US_W'(1);

        // Sweep arithmetic one bit wider than the parameter so that both
        // overflow and borrow are visible and clamp instead of wrapping.
        sum_w = {1'b0, gen_q} + {1'b0, step_sh_q};
        dif_w = {1'b0, gen_q} - {1'b0, step_sh_q};
        if (dn_sh_q) begin
            swept = dif_w[W] ? '0 : dif_w[W-1:0];
        end else begin
            swept = (sum_w > (W+1)'(PARAM_MAX)) ? W'(PARAM_MAX) : sum_w[W-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (en) do_latch = 1'b1;
            end
            S_LEAD: begin
                lead_d = lead_q + LD_W'(1);
                if (lead_q == LD_W'(LEAD_CYC - 1)) begin
                    presc_d = '0;
                    us_d    = '0;
                    if (on_sh_q == '0) begin
                        // Empty burst: skip straight to the gap, still flag it.
                        state_d = S_OFF;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        gate_d  = 1'b1;
                    end
                end
            end
            S_BURST: begin
                presc_d = presc_next;
                if (tick) begin
                    us_d = us_inc;
                    if (us_inc == US_W'(on_sh_q)) begin
                        state_d = S_OFF;
                        gate_d  = 1'b0;
                        done_d  = 1'b1;
                        presc_d = '0;
                        us_d    = '0;
                    end else if (swept != gen_q) begin
                        // Saturated ramps stop strobing the generator.
                        gen_d  = swept;
                        load_d = 1'b1;
                    end
                end
            end
            S_OFF: begin
                presc_d = presc_next;
                if (off_sh_q == '0 || (tick && us_inc == US_W'(off_sh_q))) begin
                    presc_d = '0;
                    us_d    = '0;
                    if (en) do_latch = 1'b1;
                    else    state_d  = S_IDLE;
                end else if (tick) begin
                    us_d = us_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Config is only captured here; later input changes are ignored.
        if (do_latch) begin
            on_sh_d   = on_us;
            off_sh_d  = off_us;
            step_sh_d = param_step;
            dn_sh_d   = sweep_dn;
            gen_d     = param_start;
            load_d    = 1'b1;
            lead_d    = '0;
            state_d   = S_LEAD;
        end

        // Abort overrides everything; gen_param deliberately keeps its value.
        if (kill) begin
            state_d = S_IDLE;
            gen_d   = gen_q;
            load_d  = 1'b0;
            gate_d  = 1'b0;
            done_d  = 1'b0;
            presc_d = '0;
            us_d    = '0;
            lead_d  = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // All state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            on_sh_q   <= '0;
            off_sh_q  <= '0;
            step_sh_q <= '0;
            dn_sh_q   <= 1'b0;
            gen_q     <= '0;
            load_q    <= 1'b0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            presc_q   <= '0;
            us_q      <= '0;
            lead_q    <= '0;
        end else begin
            state_q   <= state_d;
            on_sh_q   <= on_sh_d;
            off_sh_q  <= off_sh_d;
            step_sh_q <= step_sh_d;
            dn_sh_q   <= dn_sh_d;
            gen_q     <= gen_d;
            load_q    <= load_d;
            gate_q    <= gate_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            presc_q   <= presc_d;
            us_q      <= us_d;
            lead_q    <= lead_d;
        end
    end

    assign gen_param  = gen_q;
    assign param_load = load_q;
    assign gate       = gate_q;
    assign burst_done = done_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_burst_sweep_ctrl.sv
// Testbench for burst_sweep_ctrl: randomized bursts checked against a
// sequence-level model; expected loads, gate lengths and gap lengths are
// queued by the driver and consumed by an independent monitor.
module tb_burst_sweep_ctrl;

    localparam int CLK_MHZ = 100;
    localparam int PMAX    = 255;
    localparam int LEAD    = 4;
    localparam int W       = 8;
    localparam int ON_W    = 8;
    localparam int OFF_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             kill;
    logic [ON_W-1:0]  on_us;
    logic [OFF_W-1:0] off_us;
    logic [W-1:0]     param_start;
    logic [W-1:0]     param_step;
    logic             sweep_dn;
    logic [W-1:0]     gen_param;
    logic             param_load;
    logic             gate;
    logic             burst_done;
    logic             busy;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_load_q[$];
    logic [31:0]  exp_glen_q[$];
    logic         exp_gdone_q[$];
    logic [31:0]  exp_off_q[$];

    burst_sweep_ctrl #(
        .CLK_MHZ(CLK_MHZ), .PARAM_MAX(PMAX), .ON_US_MAX(255),
        .OFF_US_MAX(65535), .LEAD_CYC(LEAD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .kill(kill),
        .on_us(on_us), .off_us(off_us), .param_start(param_start),
        .param_step(param_step), .sweep_dn(sweep_dn),
        .gen_param(gen_param), .param_load(param_load), .gate(gate),
        .burst_done(burst_done), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s unexpected event actual=%0d expected=none", name, act);
    endtask

    // Reference model: one on/off sequence at the level of microseconds.
    task automatic push_expect(input int on, input int off, input int st,
                               input int stp, input bit dn, input bit relatch);
        int v, nv;
        exp_load_q.push_back(st[W-1:0]);
        v = st;
        for (int k = 1; k < on; k++) begin
            nv = dn ? v - stp : v + stp;
            if (nv < 0) nv = 0;
            if (nv > PMAX) nv = PMAX;
            if (nv != v) exp_load_q.push_back(nv[W-1:0]);
            v = nv;
        end
        if (on > 0) begin
            exp_glen_q.push_back(on * CLK_MHZ);
            exp_gdone_q.push_back(1'b1);
        end
        if (relatch) exp_off_q.push_back((off == 0) ? 1 : off * CLK_MHZ);
    endtask

    task automatic set_cfg(input int on, input int off, input int st, input int stp, input bit dn);
        on_us       = ON_W'(on);
        off_us      = OFF_W'(off);
        param_start = W'(st);
        param_step  = W'(stp);
        sweep_dn    = dn;
    endtask

    // Driver: runs n sequences with one config, optionally scrambling inputs mid-burst.
    task automatic run_episode(input int on, input int off, input int st, input int stp,
                               input bit dn, input int n, input bit force_scr);
        int c, wd;
        bit scr, to;
        set_cfg(on, off, st, stp, dn);
        en = 1'b1;
        push_expect(on, off, st, stp, dn, n > 1);
        c = 0; wd = 0; scr = 0; to = 0;
        while (c < n && !to) begin
            @(negedge clk);
            wd++;
            if (burst_done) begin
                c++;
                set_cfg(on, off, st, stp, dn);
                en  = (c < n);
                scr = 0;
                wd  = 0;
                if (c < n) push_expect(on, off, st, stp, dn, (c + 1) < n);
            end else if (gate && !scr && (force_scr || $urandom_range(0, 99) == 0)) begin
                on_us       = force_scr ? ON_W'(7) : ON_W'($urandom_range(0, 255));
                off_us      = OFF_W'($urandom_range(0, 65535));
                param_start = W'($urandom_range(0, 255));
                param_step  = W'($urandom_range(0, 255));
                sweep_dn    = 1'($urandom_range(0, 1));
                if (c == n - 1) en = 1'b0;
                scr = 1;
            end
            if (wd > 3000) begin
                errors++;
                checks++;
                $display("FAIL episode_timeout actual=no burst_done required=burst_done within 3000 cycles");
                to = 1;
            end
        end
        en = 1'b0;
        wd = 0;
        while (busy && wd < 3000) begin
            @(negedge clk);
            wd++;
        end
        chk("idle_busy", 32'(busy), 0);
        chk("idle_gate", 32'(gate), 0);
    endtask

    // Driver: abort 50 cycles into a burst while en is still high.
    task automatic kill_test();
        int wd, cnt;
        bit seen;
        set_cfg(2, 3, 100, 0, 0);
        en = 1'b1;
        exp_load_q.push_back(W'(100));
        exp_glen_q.push_back(50);
        exp_gdone_q.push_back(1'b0);
        wd = 0;
        while (!gate && wd < 100) begin
            @(negedge clk);
            wd++;
        end
        chk("kill_gate_rose", 32'(gate), 1);
        cnt = 1;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        en   = 1'b0;
        chk("kill_gate", 32'(gate), 0);
        chk("kill_busy", 32'(busy), 0);
        chk("kill_done", 32'(burst_done), 0);
        chk("kill_gen_hold", 32'(gen_param), 100);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (burst_done || busy) seen = 1;
        end
        chk("kill_quiet", 32'(seen), 0);
    endtask

    // Monitor / scoreboard: consumes expectations as the DUT presents events.
    bit          mon_en = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          glen = 0;
    bit          gate_prev = 0;
    bit          gate_seen = 0;
    bit          done_pending = 0;
    logic [31:0] tmp;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (param_load) begin
                if (exp_load_q.size() == 0) unexpected("load", 32'(gen_param));
                else chk("load_value", 32'(gen_param), 32'(exp_load_q.pop_front()));
                if (!gate) begin
                    if (done_pending) begin
                        if (exp_off_q.size() == 0) unexpected("off_len", cyc - done_cyc);
                        else chk("off_len", cyc - done_cyc, exp_off_q.pop_front());
                        done_pending = 0;
                    end
                    start_cyc = cyc;
                    gate_seen = 0;
                end
            end
            if (gate) begin
                if (!gate_prev) begin
                    chk("lead_to_gate", cyc - start_cyc, LEAD);
                    gate_seen = 1;
                    glen = 1;
                end else begin
                    glen++;
                end
            end else if (gate_prev) begin
                if (exp_glen_q.size() == 0) begin
                    unexpected("gate_len", glen);
                end else begin
                    chk("gate_len", glen, exp_glen_q.pop_front());
                    tmp = 32'(exp_gdone_q.pop_front());
                    chk("done_at_gate_fall", 32'(burst_done), tmp);
                end
            end
            if (burst_done) begin
                if (!gate_seen) chk("lead_to_done", cyc - start_cyc, LEAD);
                done_pending = 1;
                done_cyc = cyc;
            end
            if (!busy) done_pending = 0;
            gate_prev = gate;
        end
    end

    // Global time bound
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL global_timeout actual=still running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Main stimulus
    initial begin
        int on, off, n;
        rst_n = 1'b0;
        kill  = 1'b0;
        en    = 1'b1;
        set_cfg(2, 3, 100, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_gen_param", 32'(gen_param), 0);
        chk("rst_param_load", 32'(param_load), 0);
        chk("rst_gate", 32'(gate), 0);
        chk("rst_burst_done", 32'(burst_done), 0);
        chk("rst_busy", 32'(busy), 0);
        mon_en = 1;
        rst_n  = 1'b1;

        run_episode(2, 3, 100, 0, 0, 2, 0);
        run_episode(5, 2, 250, 3, 0, 1, 0);
        run_episode(4, 1, 4, 3, 1, 1, 0);
        run_episode(0, 0, 77, 5, 0, 4, 0);
        kill_test();
        run_episode(3, 1, 40, 10, 0, 1, 0);
        run_episode(2, 3, 120, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            on  = $urandom_range(0, 4);
            off = $urandom_range(0, 3);
            n   = $urandom_range(1, 3);
            run_episode(on, off, $urandom_range(0, 255), $urandom_range(0, 100),
                        1'($urandom_range(0, 1)), n, 0);
        end

        repeat (5) @(negedge clk);
        chk("load_q_empty", exp_load_q.size(), 0);
        chk("gate_q_empty", exp_glen_q.size(), 0);
        chk("off_q_empty", exp_off_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
